bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Round-robin arbiter for the single shared memory bus used by the core's bus requesters: page-table walker, instruction/data address fetch, and store writeback.
- Issues exactly one registered, one-hot grant at a time and holds it while the winner's transaction runs, as signalled by the OR-ed bus_busy.
- Adds a grant-acceptance timeout and a fixed bus turnaround cycle.
- Replaces the simple fixed-order controller. Supports an optional absolute priority for requester 0 (page walker), so translation never starves behind stores.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = page walker, 1 = addr/data, 2 = store data.
- ID_WIDTH, 2, width of out_grant_id; must satisfy 2**ID_WIDTH >= NUM_REQ.
- GRANT_TIMEOUT, 16, cycles a granted requester has to raise bus_busy before its grant is revoked.
- PRIO0_ENABLE, 1, 1 = requester 0 wins over round-robin whenever it requests in IDLE.

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- in_reqcyc  input  NUM_REQ  per-requester request level; bit i held high until the transaction is done
- in_bus_busy  input  1  OR of all requesters' busy outputs; high while the granted transaction occupies the bus
- out_grant  output  NUM_REQ  one-hot grant, registered
- out_grant_valid  output  1  OR of out_grant, registered
- out_grant_id  output  ID_WIDTH  binary index of the granted requester; 0 when no grant
- out_timeout  output  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (asynchronous, active-high) forces these values; all outputs come directly from flops:
  - state = IDLE
  - out_grant = 0, out_grant_valid = 0, out_grant_id = 0, out_timeout = 0
  - wait_cnt = 0
  - last_winner = NUM_REQ-1, so requester 0 wins first
- States: IDLE, GRANTED, BUSY, RELEASE.
- IDLE:
  - Arbitrate only if |in_reqcyc and !in_bus_busy. A busy level seen in IDLE means the bus is still draining; no grant is issued.
  - If PRIO0_ENABLE and in_reqcyc[0]: winner = 0.
  - Otherwise winner = first set bit scanning last_winner+1 upward, wrapping modulo NUM_REQ.
  - On the next edge: out_grant = onehot(winner), out_grant_id = winner, last_winner = winner, wait_cnt = 0, state -> GRANTED.
  - Latency: request sampled in cycle t, grant visible in cycle t+1.
- GRANTED:
  - Grant held. Checks in priority order:
    - in_bus_busy -> BUSY; grant kept.
    - Winner's in_reqcyc low -> RELEASE; grant cleared at this edge.
    - wait_cnt == GRANT_TIMEOUT-1 -> RELEASE; grant cleared; out_timeout = 1 for one cycle.
    - Otherwise wait_cnt++.
  - Busy on the same cycle as the timeout terminal count: busy wins, no timeout.
- BUSY:
  - Grant held while in_bus_busy is high.
  - in_bus_busy low -> RELEASE; grant cleared at that edge, whatever the state of in_reqcyc.
- RELEASE:
  - One turnaround cycle with no grant.
  - Next edge -> IDLE unconditionally.
  - Back-to-back transactions therefore have a minimum of 2 cycles with no grant between them.
- A requester that keeps in_reqcyc high after its transaction competes again under round-robin.
  - With PRIO0_ENABLE, requester 0 can monopolise the bus; this is intended, since walker traffic is bounded.
- Invariants:
  - $onehot0(out_grant) always.
  - out_grant never changes in GRANTED or BUSY except on the exit transitions listed above.
- A reset asserted mid-transaction drops the grant immediately and asynchronously; the requesters are reset by the same signal.
- wait_cnt width = $clog2(GRANT_TIMEOUT)+1; it does not wrap within its range.

Decomposition:
- Shared package bus_arb_pkg holds:
  - the state enum arb_state_t {IDLE, GRANTED, BUSY, RELEASE}
  - requester index constants REQ_VA_PA = 0, REQ_ADDR_DATA = 1, REQ_STORE_DATA = 2
- One combinational sub-module rr_pick:
  - Inputs: req vector and last_winner.
  - Outputs: winner index and a found flag.
  - Reused by later multi-port arbiters.
- The FSM, counter and output registers stay in bus_arbiter_rr.

Test Plan:
- Reset, then in_reqcyc = 3'b110 in cycle 1 -> out_grant = 3'b010 and out_grant_id = 1 in cycle 2. After busy high 3 cycles then low: grant drops, one RELEASE cycle, then out_grant = 3'b100.
- in_reqcyc = 3'b111 held with PRIO0_ENABLE = 0, each grant answered by a 1-cycle busy -> grant order 0, 1, 2, 0, with exactly 2 no-grant cycles between grants.
- PRIO0_ENABLE = 1, in_reqcyc = 3'b110 with requester 1 granted, then req0 rises during BUSY -> grant 1 is not preempted; next grant is 3'b001, not 3'b100.
- Grant to requester 2, busy never raised, GRANT_TIMEOUT = 16 -> grant held exactly 16 cycles, then cleared with a single out_timeout pulse; the next arbitration starts after the RELEASE cycle.
- in_bus_busy high while IDLE with requests pending -> no grant until busy falls; grant appears on the cycle after the falling busy is sampled.
- Assert reset while in BUSY -> out_grant = 0 asynchronously (before the next clk edge). After reset release with in_reqcyc = 3'b111, first grant = 3'b001.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arb_pkg: shared state encoding and requester indices for the bus arbiters
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam int REQ_VA_PA      = 0;
    localparam int REQ_ADDR_DATA  = 1;
    localparam int REQ_STORE_DATA = 2;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// bus_arb_if: request/busy inputs and grant outputs of the shared memory bus arbiter
interface bus_arb_if #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]  in_reqcyc;
    logic                in_bus_busy;
    logic [NUM_REQ-1:0]  out_grant;
    logic                out_grant_valid;
    logic [ID_WIDTH-1:0] out_grant_id;
    logic                out_timeout;

    modport master (
        input  in_reqcyc, in_bus_busy,
        output out_grant, out_grant_valid, out_grant_id, out_timeout
    );

    modport slave (
        output in_reqcyc, in_bus_busy,
        input  out_grant, out_grant_valid, out_grant_id, out_timeout
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: first requester after i_last in circular order, with a found flag
module rr_pick #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last,
    output logic [ID_WIDTH-1:0] o_winner,
    output logic                o_found
);
    // scan from the farthest slot back to the nearest so the nearest set bit wins
    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NUM_REQ]) begin
                o_winner = ID_WIDTH'((int'(i_last) + k) % NUM_REQ);
                o_found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin single-grant arbiter with grant timeout and turnaround cycle
import bus_arb_pkg::*;

module bus_arbiter_rr #(
    parameter int NUM_REQ       = 3,
    parameter int ID_WIDTH      = 2,
    parameter int GRANT_TIMEOUT = 16,
    parameter int PRIO0_ENABLE  = 1
) (
    input  logic      clk,
    input  logic      reset,
    bus_arb_if.master bus
);
    localparam int CW = $clog2(GRANT_TIMEOUT) + 1;

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;
    logic [ID_WIDTH-1:0] r_last;
    logic                r_timeout;
    logic [CW-1:0]       r_wait;

    logic [ID_WIDTH-1:0] w_pick;
    logic                w_found;
    logic [ID_WIDTH-1:0] w_winner;
    logic                w_req_held;
    logic                w_tc;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_pick (
        .i_req    (bus.in_reqcyc),
        .i_last   (r_last),
        .o_winner (w_pick),
        .o_found  (w_found)
    );

    // the page walker bypasses round-robin when absolute priority is enabled
    assign w_winner   = (PRIO0_ENABLE != 0 && bus.in_reqcyc[REQ_VA_PA]) ? ID_WIDTH'(REQ_VA_PA) : w_pick;
    assign w_req_held = bus.in_reqcyc[r_id];
    assign w_tc       = r_wait == CW'(GRANT_TIMEOUT - 1);

    // grant FSM: arbitrate in IDLE, hold through GRANTED/BUSY, one dead cycle in RELEASE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_last    <= ID_WIDTH'(NUM_REQ - 1);
            r_timeout <= 1'b0;
            r_wait    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: if (w_found && !bus.in_bus_busy) begin
                    r_grant <= NUM_REQ'(1) << w_winner;
                    r_valid <= 1'b1;
                    r_id    <= w_winner;
                    r_last  <= w_winner;
                    r_wait  <= '0;
                    r_state <= GRANTED;
                end
                GRANTED: if (bus.in_bus_busy) begin
                    r_state <= BUSY;
                end else if (!w_req_held || w_tc) begin
                    r_grant   <= '0;
                    r_valid   <= 1'b0;
                    r_id      <= '0;
                    r_timeout <= w_req_held;
                    r_state   <= RELEASE;
                end else begin
                    r_wait <= r_wait + CW'(1);
                end
                BUSY: if (!bus.in_bus_busy) begin
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_id    <= '0;
                    r_state <= RELEASE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_grant       = r_grant;
    assign bus.out_grant_valid = r_valid;
    assign bus.out_grant_id    = r_id;
    assign bus.out_timeout     = r_timeout;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: two arbiters (priority on/off) on shared stimulus, checked against a transaction-level model
module tb_bus_arbiter_rr;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;

    bus_arb_if #(.NUM_REQ(3), .ID_WIDTH(2)) if_p ();
    bus_arb_if #(.NUM_REQ(3), .ID_WIDTH(2)) if_r ();

    bus_arbiter_rr #(.NUM_REQ(3), .ID_WIDTH(2), .GRANT_TIMEOUT(16), .PRIO0_ENABLE(1)) u_dut_p (
        .clk   (clk),
        .reset (reset),
        .bus   (if_p)
    );

    bus_arbiter_rr #(.NUM_REQ(3), .ID_WIDTH(2), .GRANT_TIMEOUT(16), .PRIO0_ENABLE(0)) u_dut_r (
        .clk   (clk),
        .reset (reset),
        .bus   (if_r)
    );

    always #5 clk = ~clk;

    // model per arbiter: who owns the bus, whether the owner has started its transfer,
    // whether we are in the turnaround gap, how long the owner has idled, who won last
    int owner[2];
    int last[2];
    int age[2];
    bit started[2];
    bit gap[2];
    bit tmo[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            last[k] = 2;
            age[k] = 0;
            started[k] = 1'b0;
            gap[k] = 1'b0;
            tmo[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(input int k, input logic [2:0] req, input logic busy);
        tmo[k] = 1'b0;
        if (gap[k]) begin
            gap[k] = 1'b0;
        end else if (owner[k] < 0) begin
            if (req != 3'b000 && !busy) begin
                int w;
                w = -1;
                if (k == 0 && req[0]) w = 0;
                for (int s = 1; s <= 3 && w < 0; s++)
                    if (req[(last[k] + s) % 3]) w = (last[k] + s) % 3;
                owner[k] = w;
                last[k] = w;
                age[k] = 0;
                started[k] = 1'b0;
            end
        end else if (started[k]) begin
            if (!busy) begin
                owner[k] = -1;
                gap[k] = 1'b1;
            end
        end else if (busy) begin
            started[k] = 1'b1;
        end else if (!req[owner[k]]) begin
            owner[k] = -1;
            gap[k] = 1'b1;
        end else if (age[k] == 15) begin
            owner[k] = -1;
            gap[k] = 1'b1;
            tmo[k] = 1'b1;
        end else begin
            age[k]++;
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [2:0] g;
            logic [1:0] id;
            logic v;
            logic t;
            g  = k == 0 ? if_p.out_grant       : if_r.out_grant;
            id = k == 0 ? if_p.out_grant_id    : if_r.out_grant_id;
            v  = k == 0 ? if_p.out_grant_valid : if_r.out_grant_valid;
            t  = k == 0 ? if_p.out_timeout     : if_r.out_timeout;
            check($sformatf("arb%0d.grant", k), 32'(g), owner[k] < 0 ? 0 : 32'(1) << owner[k]);
            check($sformatf("arb%0d.id", k), 32'(id), owner[k] < 0 ? 0 : 32'(owner[k]));
            check($sformatf("arb%0d.valid", k), 32'(v), 32'(owner[k] >= 0));
            check($sformatf("arb%0d.timeout", k), 32'(t), 32'(tmo[k]));
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic busy);
        if_p.in_reqcyc = req;
        if_r.in_reqcyc = req;
        if_p.in_bus_busy = busy;
        if_r.in_bus_busy = busy;
    endtask

    task automatic cycle(input logic [2:0] req, input logic busy);
        @(negedge clk);
        drive(req, busy);
        @(posedge clk);
        model_step(0, req, busy);
        model_step(1, req, busy);
        #1;
        compare_all();
    endtask

    logic [2:0] rr_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        logic [2:0] req;
        int bp;
        drive(3'b000, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        cycle(3'b110, 1'b0);
        check("t1.grant", 32'(if_p.out_grant), 32'b010);
        check("t1.id", 32'(if_p.out_grant_id), 1);
        repeat (3) cycle(3'b110, 1'b1);
        cycle(3'b110, 1'b0);
        check("t1.release", 32'(if_p.out_grant), 0);
        cycle(3'b110, 1'b0);
        cycle(3'b110, 1'b0);
        check("t1.next", 32'(if_p.out_grant), 32'b100);
        check("t1.next_rr", 32'(if_r.out_grant), 32'b100);
        cycle(3'b110, 1'b1);
        cycle(3'b111, 1'b0);

        for (int i = 0; i < 4; i++) begin
            cycle(3'b111, 1'b0);
            check("t2.gap", 32'(if_r.out_grant), 0);
            cycle(3'b111, 1'b0);
            check("t2.order", 32'(if_r.out_grant), 32'(rr_order[i]));
            check("t2.prio", 32'(if_p.out_grant), 32'b001);
            cycle(3'b111, 1'b1);
            cycle(3'b111, 1'b0);
            check("t2.release", 32'(if_r.out_grant), 0);
        end

        cycle(3'b110, 1'b0);
        cycle(3'b110, 1'b0);
        check("t3.grant", 32'(if_p.out_grant), 32'b010);
        cycle(3'b110, 1'b1);
        cycle(3'b111, 1'b1);
        check("t3.nopreempt", 32'(if_p.out_grant), 32'b010);
        cycle(3'b111, 1'b0);
        cycle(3'b111, 1'b0);
        cycle(3'b111, 1'b0);
        check("t3.prio_next", 32'(if_p.out_grant), 32'b001);
        cycle(3'b111, 1'b1);
        cycle(3'b000, 1'b0);
        cycle(3'b000, 1'b0);

        cycle(3'b100, 1'b0);
        check("t4.grant", 32'(if_p.out_grant), 32'b100);
        for (int i = 1; i < 16; i++) begin
            cycle(3'b100, 1'b0);
            check("t4.hold", 32'(if_p.out_grant), 32'b100);
        end
        cycle(3'b100, 1'b0);
        check("t4.revoked", 32'(if_p.out_grant), 0);
        check("t4.pulse", 32'(if_p.out_timeout), 1);
        cycle(3'b000, 1'b0);
        check("t4.pulse_end", 32'(if_p.out_timeout), 0);

        repeat (3) begin
            cycle(3'b011, 1'b1);
            check("t5.drain", 32'(if_p.out_grant), 0);
        end
        cycle(3'b011, 1'b0);
        check("t5.grant", 32'(if_p.out_grant), 32'b001);
        cycle(3'b011, 1'b1);
        cycle(3'b011, 1'b0);
        cycle(3'b000, 1'b0);

        cycle(3'b010, 1'b0);
        cycle(3'b010, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6.async_p", 32'(if_p.out_grant), 0);
        check("t6.async_r", 32'(if_r.out_grant), 0);
        model_reset();
        @(negedge clk);
        drive(3'b111, 1'b0);
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        cycle(3'b111, 1'b0);
        check("t6.first_p", 32'(if_p.out_grant), 32'b001);
        check("t6.first_r", 32'(if_r.out_grant), 32'b001);

        req = 3'b000;
        bp = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) bp = 10 * $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            cycle(req, $urandom_range(0, 99) < bp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
